// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and counter sizing.
package pulse_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HIGH = 2'b01;
    localparam logic [1:0] ST_LOW  = 2'b10;

    // Bits needed for a down-counter that must hold max(width, gap).
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned gap);
        int unsigned m;
        m = (width > gap) ? width : gap;
        return 32'($clog2(m + 1));
    endfunction

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Up/down counter that saturates at MAX and floors at zero; simultaneous inc and dec hold.
module sat_counter #(
    parameter int unsigned MAX = 3,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !at_max) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == W'(MAX));

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into WIDTH-high / GAP-low pulses, queueing
// triggers that arrive while a pulse is in progress.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned GAP      = 2,
    parameter int unsigned PEND_MAX = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              trig,
    input  logic                              clr_ovf,
    output logic                              z,
    output logic                              busy,
    output logic [$clog2(PEND_MAX + 1)-1:0]   pending,
    output logic                              overflow
);

    localparam int unsigned CW = cnt_width(WIDTH, GAP);
    localparam int unsigned PW = $clog2(PEND_MAX + 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          z_q;
    logic          z_d;
    logic          busy_q;
    logic          busy_d;
    logic          ovf_q;
    logic          ovf_d;

    logic in_busy;
    logic cnt_zero;
    logic low_end;
    logic pend_zero;
    logic pend_at_max;
    logic pend_inc;
    logic pend_dec;
    logic drop;

    assign in_busy   = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign cnt_zero  = (cnt_q == '0);
    assign low_end   = (state_q == ST_LOW) && cnt_zero;
    assign pend_zero = (pending == '0);

    // A trigger at the end of LOW with nothing queued starts the next pulse directly.
    assign pend_dec = low_end && !pend_zero;
    assign pend_inc = trig && in_busy && !(low_end && pend_zero);
    assign drop     = pend_inc && pend_at_max && !pend_dec;

    sat_counter #(
        .MAX (PEND_MAX),
        .W   (PW)
    ) u_pend (
        .clk    (clk),
        .reset  (reset),
        .inc    (pend_inc),
        .dec    (pend_dec),
        .count  (pending),
        .at_max (pend_at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state and phase counter; the unused encoding behaves as IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HIGH: begin
                if (cnt_zero) begin
                    state_d = ST_LOW;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_LOW: begin
                if (cnt_zero) begin
                    if (!pend_zero || trig) begin
                        state_d = ST_HIGH;
                        cnt_d   = CW'(WIDTH - 1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (trig) begin
                    state_d = ST_HIGH;
                    cnt_d   = CW'(WIDTH - 1);
                end
            end
        endcase
    end

    // Outputs follow the next state so they change on the same edge as the state.
    always_comb begin
        z_d    = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
        ovf_d  = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    assign z        = z_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with WIDTH=4, GAP=2, PEND_MAX=2.
module tb_pulse_stretcher;

    logic       clk;
    logic       reset;
    logic       trig;
    logic       clr_ovf;
    logic       z;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int unsigned n_checks;
    int unsigned n_errors;

    pulse_stretcher #(
        .WIDTH    (4),
        .GAP      (2),
        .PEND_MAX (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .trig     (trig),
        .clr_ovf  (clr_ovf),
        .z        (z),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input int i, input int unsigned ez,
                              input int unsigned eb, input int unsigned ep, input int unsigned eo);
        check($sformatf("%s[%0d].z", tag, i), 32'(z), ez);
        check($sformatf("%s[%0d].busy", tag, i), 32'(busy), eb);
        check($sformatf("%s[%0d].pending", tag, i), 32'(pending), ep);
        check($sformatf("%s[%0d].overflow", tag, i), 32'(overflow), eo);
    endtask

    // Drive inputs for one edge, then sample just after it.
    task automatic tick(input logic t, input logic c);
        trig    = t;
        clr_ovf = c;
        @(posedge clk);
        #1;
        trig    = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        for (int k = 0; k < max_cycles && busy; k++) tick(1'b0, 1'b0);
        check({tag, ".idle"}, 32'(busy), 0);
    endtask

    int unsigned ez, eb, ep, eo;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        trig     = 1'b0;
        clr_ovf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick(1'b0, 1'b0);

        // single trigger: 4 high, 2 low, then idle
        for (int i = 0; i <= 6; i++) begin
            tick(i == 0, 1'b0);
            ez = (i < 4) ? 1 : 0;
            eb = (i < 6) ? 1 : 0;
            expect_all("single", i, ez, eb, 0, 0);
        end

        // second trigger queued during the first pulse
        for (int i = 0; i <= 12; i++) begin
            tick(i == 0 || i == 2, 1'b0);
            ez = ((i < 4) || (i >= 6 && i < 10)) ? 1 : 0;
            eb = (i < 12) ? 1 : 0;
            ep = (i >= 2 && i < 6) ? 1 : 0;
            expect_all("queued", i, ez, eb, ep, 0);
        end

        // trigger exactly at LOW end with nothing queued: no idle cycle
        for (int i = 0; i <= 12; i++) begin
            tick(i == 0 || i == 6, 1'b0);
            ez = ((i % 6) < 4 && i < 12) ? 1 : 0;
            eb = (i < 12) ? 1 : 0;
            expect_all("lowend_idle", i, ez, eb, 0, 0);
        end

        // four consecutive triggers: saturate at 2, drop one, three pulses
        for (int i = 0; i <= 18; i++) begin
            tick(i < 4, 1'b0);
            ez = ((i % 6) < 4 && i < 18) ? 1 : 0;
            eb = (i < 18) ? 1 : 0;
            ep = (i == 0) ? 0 : (i == 1) ? 1 : (i < 6) ? 2 : (i < 12) ? 1 : 0;
            eo = (i >= 3) ? 1 : 0;
            expect_all("saturate", i, ez, eb, ep, eo);
        end

        // clear overflow with no drop
        tick(1'b0, 1'b1);
        expect_all("clr", 0, 0, 0, 0, 0);

        // clear coinciding with a drop: set wins, then a plain clear works
        for (int i = 0; i <= 3; i++) begin
            tick(i < 4, i == 3);
            ep = (i == 0) ? 0 : (i == 1) ? 1 : 2;
            eo = (i == 3) ? 1 : 0;
            expect_all("clr_vs_drop", i, 1, 1, ep, eo);
        end
        tick(1'b0, 1'b1);
        check("clr_after_drop.overflow", 32'(overflow), 0);
        wait_idle("clr_after_drop", 40);

        // queue full and a trigger at LOW end: increment and decrement cancel
        for (int i = 0; i <= 24; i++) begin
            tick(i == 0 || i == 1 || i == 2 || i == 6, 1'b0);
            ez = ((i % 6) < 4 && i < 24) ? 1 : 0;
            eb = (i < 24) ? 1 : 0;
            ep = (i == 0) ? 0 : (i == 1) ? 1 : (i < 12) ? 2 : (i < 18) ? 1 : 0;
            expect_all("full_lowend", i, ez, eb, ep, 0);
        end

        // asynchronous reset in the middle of a pulse
        for (int i = 0; i <= 3; i++) tick(1'b1, 1'b0);
        expect_all("pre_reset", 3, 1, 1, 2, 1);
        #2;
        reset = 1'b1;
        #1;
        expect_all("async_reset", 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            tick(i == 0, 1'b0);
            ez = (i < 4) ? 1 : 0;
            eb = (i < 6) ? 1 : 0;
            expect_all("after_reset", i, ez, eb, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
